// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock,
// start/ready handshake in, one-cycle done pulse out.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;
  // Divide-by-zero result still to be published from DONE.
  logic             zpend_q, zpend_d;

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign q_out       = q_out_q;
  assign r_out       = r_out_q;
  assign div_by_zero = dbz_q;

  // Next-state, datapath iteration and result capture.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    zpend_d = zpend_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;

    shifted_rem = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial       = shifted_rem - {1'b0, div_q};

    unique case (state_q)
      IDLE: begin
        zpend_d = 1'b0;
        if (start) begin
          rem_d = '0;
          quo_d = a_in;
          div_d = b_in;
          cnt_d = CW'(WIDTH);
          if (b_in == '0) begin
            // Zero divisor skips the iteration; DONE publishes it one edge later.
            zpend_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        if (!trial[WIDTH]) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_rem;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_out_d = quo_d;
          r_out_d = rem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (zpend_q) begin
          // quo still holds the sampled dividend on this path.
          q_out_d = '1;
          r_out_d = quo_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          zpend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
    end
  end

  // Working registers; only meaningful while busy, so never reset.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    div_q <= div_d;
    cnt_q <= cnt_d;
  end

endmodule
